// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, receiver state encoding
// and the baud-select encodings used by the baud generator.
package uart_pkg;

    localparam int OS_RATE    = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_38400  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_sel_t;

    // Half period of baud_clk in 50 MHz system clocks for each select value.
    function automatic int unsigned baud_half_period(input baud_sel_t sel);
        case (sel)
            BAUD_9600:   return 164;
            BAUD_19200:  return 82;
            BAUD_38400:  return 41;
            default:     return 14;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer handshake: the receiver (master) presents a word with
// flags, the consumer (slave) accepts it with rx_ready.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_parity_err,
        output rx_overrun
    );

    modport slave (
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_overrun
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: two-flop synchronizer on the
// serial line (idles high out of reset) and rising-edge detect on baud_clk.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_serial,
    input  logic baud_clk,
    output logic rx_s,
    output logic tick
);
    logic rx_meta;
    logic baud_q;

    // Synchronize the asynchronous line and delay baud_clk for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            baud_q  <= 1'b0;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
            baud_q  <= baud_clk;
        end
    end

    assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine with 16x oversampling and a valid/ready output.
// Optional parity support is enabled by defining UART_RX_PARITY_EN; without
// it there is no parity bit, no parity_odd port and rx_parity_err is 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      baud_clk,
    input  logic      rx_serial,
`ifdef UART_RX_PARITY_EN
    input  logic      parity_odd,
`endif
    uart_rx_if.master rx_bus
);
    localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
    localparam logic [3:0] OS_MID   = 4'(MID_SAMPLE);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 tick;
    rx_state_t            state, state_next;
    logic [3:0]           os_cnt, os_next;
    logic [2:0]           bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift_q;
    logic                 shift_en;
    logic                 load_en;

    uart_rx_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .baud_clk  (baud_clk),
        .rx_s      (rx_s),
        .tick      (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_en;
    logic perr_q;
    logic parity_err_q;
`endif

    // State register plus the oversample counter and bit index it controls.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            os_cnt  <= 4'd0;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_next;
            os_cnt  <= os_next;
            bit_idx <= idx_next;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_next = state;
        os_next    = os_cnt;
        idx_next   = bit_idx;
        shift_en   = 1'b0;
        load_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_en    = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        os_next    = 4'd0;
                        state_next = START;
                    end
                end
                START: begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == OS_MID) begin
                        if (!rx_s) begin
                            os_next    = 4'd0;
                            idx_next   = 3'd0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == OS_LAST) begin
                        shift_en = 1'b1;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            idx_next = bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == OS_LAST) begin
                        perr_en    = 1'b1;
                        state_next = STOP;
                    end
                end
`endif
                STOP: begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == OS_LAST) begin
                        load_en    = 1'b1;
                        state_next = rx_s ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Data bits arrive LSB first, so shift each new bit in at the top.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity check over data plus received parity bit against the selected sense.
    always_ff @(posedge clock) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (perr_en) begin
            perr_q <= ^{shift_q, rx_s} ^ parity_odd;
        end
    end

    // Parity flag is part of the held word and loads with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (load_en) begin
            parity_err_q <= perr_q;
        end
    end

    assign rx_bus.rx_parity_err = parity_err_q;
`else
    assign rx_bus.rx_parity_err = 1'b0;
`endif

    // Output word register and handshake; a load wins over a plain accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_bus.rx_data      <= '0;
            rx_bus.rx_frame_err <= 1'b0;
            rx_bus.rx_valid     <= 1'b0;
            rx_bus.rx_overrun   <= 1'b0;
        end else if (load_en) begin
            rx_bus.rx_data      <= shift_q;
            rx_bus.rx_frame_err <= ~rx_s;
            rx_bus.rx_valid     <= 1'b1;
            rx_bus.rx_overrun   <= rx_bus.rx_valid & ~rx_bus.rx_ready;
        end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
            rx_bus.rx_valid     <= 1'b0;
            rx_bus.rx_overrun   <= 1'b0;
        end
    end

endmodule
